// File: rtl/j1_io_fabric.sv
`default_nettype none
// ============================================================================
// Module   : j1_io_fabric
// Purpose  : I/O interconnect between the J1 core and its memory-mapped
//            peripherals. Decodes a run of 256-word pages into one-hot chip
//            selects, muxes peripheral read data back to the core (optionally
//            registered), and provides a status page that records accesses
//            to unmapped pages.
// Ports    : sys_clk_i/sys_rst_i    clock, async active-low reset
//            io_rd/io_wr/io_addr/io_dout/io_din   J1 I/O bus
//            per_cs/per_addr/per_rd/per_wr/per_wdata/per_rdata  peripherals
//            err_irq                registered OR of the error flags
// Revision : 1.0  initial release
// ============================================================================
module j1_io_fabric #(
   parameter int          NUM_SLOTS     = 8,
   parameter logic [7:0]  BASE_PAGE     = 8'h67,
   parameter bit          REG_RDATA     = 1'b0,
   parameter logic [15:0] DEFAULT_RDATA = 16'h0666
) (
   input  logic                    sys_clk_i,
   input  logic                    sys_rst_i,
   input  logic                    io_rd,
   input  logic                    io_wr,
   input  logic [15:0]             io_addr,
   input  logic [15:0]             io_dout,
   output logic [15:0]             io_din,
   output logic [NUM_SLOTS-1:0]    per_cs,
   output logic [3:0]              per_addr,
   output logic                    per_rd,
   output logic                    per_wr,
   output logic [15:0]             per_wdata,
   input  logic [16*NUM_SLOTS-1:0] per_rdata,
   output logic                    err_irq
);

   // 9-bit page arithmetic so BASE_PAGE+NUM_SLOTS cannot wrap.
   localparam logic [8:0]  c_STATUS_PAGE = 9'(BASE_PAGE) + 9'(NUM_SLOTS);
   localparam logic [3:0]  c_NSLOTS_LO   = 4'(NUM_SLOTS);
   localparam logic [15:0] c_ID          = {BASE_PAGE, 4'h0, c_NSLOTS_LO};

   logic [7:0]  w_page;
   logic        w_slot_hit;
   logic        w_status_hit;
   logic        w_unmapped;
   logic        w_reg_wr;
   logic [1:0]  w_flag_clr;
   logic [1:0]  w_flag_set;
   logic [1:0]  w_flags_nxt;
   logic        w_cnt_clr;
   logic [15:0] w_count_nxt;
   logic [15:0] w_status_data;
   logic [15:0] w_slot_data;
   logic [15:0] w_rdata;

   logic [1:0]  r_flags;
   logic [15:0] r_err_addr;
   logic [15:0] r_count;
   logic        r_irq;

   assign w_page    = io_addr[15:8];
   assign per_addr  = io_addr[3:0];
   assign per_rd    = io_rd;
   assign per_wr    = io_wr;
   assign per_wdata = io_dout;
   assign err_irq   = r_irq;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_cs
      assign per_cs[i] = ({1'b0, w_page} == (9'(BASE_PAGE) + 9'(i)));
   end

   assign w_slot_hit   = |per_cs;
   assign w_status_hit = ({1'b0, w_page} == c_STATUS_PAGE);
   assign w_unmapped   = (io_rd | io_wr) & ~w_slot_hit & ~w_status_hit;
   assign w_reg_wr     = io_wr & w_status_hit;

   // A new error sets its flag even if the same bit is being cleared.
   assign w_flag_clr  = (w_reg_wr && io_addr[3:0] == 4'd0) ? io_dout[1:0] : 2'b00;
   assign w_flag_set  = w_unmapped ? {io_wr, io_rd} : 2'b00;
   assign w_flags_nxt = (r_flags & ~w_flag_clr) | w_flag_set;
   assign w_cnt_clr   = w_reg_wr && (io_addr[3:0] == 4'd2);

   // Clear applies first, so clear + new error leaves the count at 1.
   always_comb begin
      w_count_nxt = w_cnt_clr ? 16'h0000 : r_count;
      if (w_unmapped && w_count_nxt != 16'hFFFF) begin
         w_count_nxt = w_count_nxt + 16'd1;
      end
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         r_flags    <= 2'b00;
         r_err_addr <= 16'h0000;
         r_count    <= 16'h0000;
         r_irq      <= 1'b0;
      end else begin
         r_flags <= w_flags_nxt;
         r_irq   <= |w_flags_nxt;
         r_count <= w_count_nxt;
         if (w_unmapped) begin
            r_err_addr <= io_addr;
         end
      end
   end

   always_comb begin
      w_status_data = 16'h0000;
      case (io_addr[3:0])
         4'd0:    w_status_data = {14'h0000, r_flags};
         4'd1:    w_status_data = r_err_addr;
         4'd2:    w_status_data = r_count;
         4'd3:    w_status_data = c_ID;
         default: w_status_data = 16'h0000;
      endcase
   end

   // per_cs is one-hot or zero, so at most one slot matches.
   always_comb begin
      w_slot_data = DEFAULT_RDATA;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (per_cs[i]) begin
            w_slot_data = per_rdata[16*i +: 16];
         end
      end
   end

   assign w_rdata = w_status_hit ? w_status_data : w_slot_data;

   if (REG_RDATA) begin : g_reg_rdata
      logic [15:0] r_din;
      // Only read cycles update the held value; write-only cycles leave it.
      always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
         if (!sys_rst_i) begin
            r_din <= 16'h0000;
         end else if (io_rd) begin
            r_din <= w_rdata;
         end
      end
      assign io_din = r_din;
   end else begin : g_comb_rdata
      assign io_din = w_rdata;
   end

endmodule
`default_nettype wire

// File: tb/tb_j1_io_fabric.sv
`default_nettype none
// ============================================================================
// Module   : tb_j1_io_fabric
// Purpose  : Directed self-checking bench for j1_io_fabric. One instance with
//            combinational read data, one with registered read data, both
//            sharing the same J1 bus and peripheral read data.
// Revision : 1.0  initial release
// ============================================================================
module tb_j1_io_fabric;

   logic         clk;
   logic         rst_n;
   logic         rd;
   logic         wr;
   logic [15:0]  addr;
   logic [15:0]  dout;
   logic [127:0] prdata;

   logic [15:0] c_din,  r_din;
   logic [7:0]  c_cs,   r_cs;
   logic [3:0]  c_paddr, r_paddr;
   logic        c_prd,  r_prd;
   logic        c_pwr,  r_pwr;
   logic [15:0] c_pwdata, r_pwdata;
   logic        c_irq,  r_irq;

   int total = 0;
   int bad   = 0;

   j1_io_fabric #(.NUM_SLOTS(8), .BASE_PAGE(8'h67), .REG_RDATA(1'b0),
                  .DEFAULT_RDATA(16'h0666)) u_comb (
      .sys_clk_i(clk), .sys_rst_i(rst_n), .io_rd(rd), .io_wr(wr),
      .io_addr(addr), .io_dout(dout), .io_din(c_din), .per_cs(c_cs),
      .per_addr(c_paddr), .per_rd(c_prd), .per_wr(c_pwr),
      .per_wdata(c_pwdata), .per_rdata(prdata), .err_irq(c_irq));

   j1_io_fabric #(.NUM_SLOTS(8), .BASE_PAGE(8'h67), .REG_RDATA(1'b1),
                  .DEFAULT_RDATA(16'h0666)) u_reg (
      .sys_clk_i(clk), .sys_rst_i(rst_n), .io_rd(rd), .io_wr(wr),
      .io_addr(addr), .io_dout(dout), .io_din(r_din), .per_cs(r_cs),
      .per_addr(r_paddr), .per_rd(r_prd), .per_wr(r_pwr),
      .per_wdata(r_pwdata), .per_rdata(prdata), .err_irq(r_irq));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d);
      rd = r; wr = w; addr = a; dout = d;
   endtask

   task automatic step();
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      total++; if (c_cs !== 8'h00) begin bad++; $display("FAIL reset_cs got=%h exp=%h", c_cs, 8'h00); end
      total++; if (c_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", c_irq); end
      total++; if (r_din !== 16'h0000) begin bad++; $display("FAIL reset_reg_din got=%h exp=0000", r_din); end
      addr = 16'h6F02; #1;
      total++; if (c_din !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h exp=0000", c_din); end
      @(negedge clk); rst_n = 1'b1;
      step();
   endtask

   task automatic test_decode();
      logic [15:0] a_tab  [6] = '{16'h6A03, 16'h6F00, 16'h6600, 16'h6700, 16'h6E0F, 16'h6B07};
      logic [7:0]  cs_tab [6] = '{8'h08, 8'h00, 8'h00, 8'h01, 8'h80, 8'h10};
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b0, a_tab[i], 16'h0000);
         @(negedge clk);
         total++; if (c_cs !== cs_tab[i]) begin bad++; $display("FAIL decode_cs addr=%h got=%h exp=%h", a_tab[i], c_cs, cs_tab[i]); end
         total++; if (c_paddr !== a_tab[i][3:0]) begin bad++; $display("FAIL decode_addr addr=%h got=%h exp=%h", a_tab[i], c_paddr, a_tab[i][3:0]); end
      end
      drive(1'b1, 1'b1, 16'h6B07, 16'hBEEF);
      @(negedge clk);
      total++; if ({c_prd, c_pwr} !== 2'b11) begin bad++; $display("FAIL pass_strobes got=%b exp=11", {c_prd, c_pwr}); end
      total++; if (c_pwdata !== 16'hBEEF) begin bad++; $display("FAIL pass_wdata got=%h exp=beef", c_pwdata); end
      step();
   endtask

   task automatic test_read_mux();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1'b0, {8'h67 + 8'(k), 8'h00}, 16'h0000);
         @(negedge clk);
         total++; if (c_din !== 16'hA000 + 16'(k)) begin bad++; $display("FAIL read_slot%0d got=%h exp=%h", k, c_din, 16'hA000 + 16'(k)); end
         step();
      end
      drive(1'b1, 1'b0, 16'h5000, 16'h0000);
      @(negedge clk);
      total++; if (c_din !== 16'h0666) begin bad++; $display("FAIL read_default got=%h exp=0666", c_din); end
      step();
      total++; if (c_irq !== 1'b1) begin bad++; $display("FAIL irq_after_unmapped_read got=%b exp=1", c_irq); end
   endtask

   task automatic test_reg_read();
      drive(1'b1, 1'b0, 16'h6900, 16'h0000);
      @(negedge clk);
      total++; if (r_din !== 16'h0666) begin bad++; $display("FAIL reg_read_latency got=%h exp=0666", r_din); end
      step();
      total++; if (r_din !== 16'hA002) begin bad++; $display("FAIL reg_read_load got=%h exp=a002", r_din); end
      drive(1'b0, 1'b1, 16'h6B00, 16'h1111);
      @(negedge clk);
      total++; if (r_din !== 16'hA002) begin bad++; $display("FAIL reg_read_hold1 got=%h exp=a002", r_din); end
      step();
      drive(1'b0, 1'b1, 16'h6C00, 16'h2222);
      step();
      total++; if (r_din !== 16'hA002) begin bad++; $display("FAIL reg_read_hold2 got=%h exp=a002", r_din); end
   endtask

   task automatic test_error_capture();
      drive(1'b0, 1'b1, 16'h6F00, 16'h0003); step();
      drive(1'b0, 1'b1, 16'h6F02, 16'h0000); step();
      drive(1'b0, 1'b0, 16'h6F00, 16'h0000);
      @(negedge clk);
      total++; if (c_din !== 16'h0000) begin bad++; $display("FAIL flags_cleared got=%h exp=0000", c_din); end
      total++; if (c_irq !== 1'b0) begin bad++; $display("FAIL irq_cleared got=%b exp=0", c_irq); end
      drive(1'b0, 1'b1, 16'h1234, 16'h0000); step();
      drive(1'b1, 1'b0, 16'h5678, 16'h0000); step();
      drive(1'b0, 1'b0, 16'h6F00, 16'h0000); #1;
      total++; if (c_din !== 16'h0003) begin bad++; $display("FAIL err_flags got=%h exp=0003", c_din); end
      addr = 16'h6F01; #1;
      total++; if (c_din !== 16'h5678) begin bad++; $display("FAIL err_addr got=%h exp=5678", c_din); end
      addr = 16'h6F02; #1;
      total++; if (c_din !== 16'h0002) begin bad++; $display("FAIL err_count got=%h exp=0002", c_din); end
      total++; if ({c_irq, r_irq} !== 2'b11) begin bad++; $display("FAIL err_irq got=%b exp=11", {c_irq, r_irq}); end
      drive(1'b1, 1'b0, 16'h6F02, 16'h0000); step();
      total++; if (r_din !== 16'h0002) begin bad++; $display("FAIL reg_status_read got=%h exp=0002", r_din); end
      drive(1'b0, 1'b1, 16'h6F00, 16'h0001); step();
      addr = 16'h6F00; #1;
      total++; if (c_din !== 16'h0002) begin bad++; $display("FAIL w1c_bit0 got=%h exp=0002", c_din); end
      total++; if (c_irq !== 1'b1) begin bad++; $display("FAIL irq_partial got=%b exp=1", c_irq); end
      drive(1'b0, 1'b1, 16'h6F00, 16'h0002); step();
      addr = 16'h6F00; #1;
      total++; if (c_din !== 16'h0000) begin bad++; $display("FAIL w1c_bit1 got=%h exp=0000", c_din); end
      total++; if (c_irq !== 1'b0) begin bad++; $display("FAIL irq_low got=%b exp=0", c_irq); end
      addr = 16'h6F03; #1;
      total++; if (c_din !== 16'h6708) begin bad++; $display("FAIL id got=%h exp=6708", c_din); end
      addr = 16'h6F09; #1;
      total++; if (c_din !== 16'h0000) begin bad++; $display("FAIL reserved got=%h exp=0000", c_din); end
   endtask

   task automatic test_simultaneous();
      drive(1'b1, 1'b1, 16'h2000, 16'h0000); step();
      addr = 16'h6F00; #1;
      total++; if (c_din !== 16'h0003) begin bad++; $display("FAIL rdwr_flags got=%h exp=0003", c_din); end
      addr = 16'h6F02; #1;
      total++; if (c_din !== 16'h0003) begin bad++; $display("FAIL rdwr_count got=%h exp=0003", c_din); end
      addr = 16'h6F01; #1;
      total++; if (c_din !== 16'h2000) begin bad++; $display("FAIL rdwr_addr got=%h exp=2000", c_din); end
      drive(1'b0, 1'b1, 16'h6F02, 16'h0000); step();
      drive(1'b0, 1'b1, 16'h0100, 16'h0000); step();
      addr = 16'h6F02; #1;
      total++; if (c_din !== 16'h0001) begin bad++; $display("FAIL count_after_clear got=%h exp=0001", c_din); end
      drive(1'b0, 1'b1, 16'h0100, 16'h0000);
      repeat (65534) @(posedge clk);
      #1; wr = 1'b0; addr = 16'h6F02; #1;
      total++; if (c_din !== 16'hFFFF) begin bad++; $display("FAIL count_full got=%h exp=ffff", c_din); end
      drive(1'b0, 1'b1, 16'h0100, 16'h0000); step();
      addr = 16'h6F02; #1;
      total++; if (c_din !== 16'hFFFF) begin bad++; $display("FAIL count_saturate got=%h exp=ffff", c_din); end
   endtask

   task automatic test_async_reset();
      total++; if (c_irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%b exp=1", c_irq); end
      @(posedge clk); #3;
      rst_n = 1'b0; addr = 16'h6F00; #1;
      total++; if ({c_irq, r_irq} !== 2'b00) begin bad++; $display("FAIL async_irq got=%b exp=00", {c_irq, r_irq}); end
      total++; if (c_din !== 16'h0000) begin bad++; $display("FAIL async_flags got=%h exp=0000", c_din); end
      total++; if (r_din !== 16'h0000) begin bad++; $display("FAIL async_reg_din got=%h exp=0000", r_din); end
      addr = 16'h6F02; #1;
      total++; if (c_din !== 16'h0000) begin bad++; $display("FAIL async_count got=%h exp=0000", c_din); end
      @(negedge clk); rst_n = 1'b1;
      drive(1'b1, 1'b0, 16'h6F03, 16'h0000);
      @(negedge clk);
      total++; if (c_din !== 16'h6708) begin bad++; $display("FAIL id_after_reset got=%h exp=6708", c_din); end
      step();
      total++; if (r_din !== 16'h6708) begin bad++; $display("FAIL reg_id_after_reset got=%h exp=6708", r_din); end
   endtask

   initial begin
      rst_n = 1'b0;
      rd = 1'b0; wr = 1'b0; addr = 16'h0000; dout = 16'h0000;
      for (int k = 0; k < 8; k++) prdata[16*k +: 16] = 16'hA000 + 16'(k);
      test_reset();
      test_decode();
      test_read_mux();
      test_reg_read();
      test_error_capture();
      test_simultaneous();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
